// File: rtl/pe_mac_array_pkg.sv
// PEMacCfg: state encoding, job configuration record and default sizes for pe_mac_array.
package PEMacCfg;
    localparam int DEF_ROWS      = 4;
    localparam int DEF_DWD       = 8;
    localparam int DEF_PSUMDWD   = 20;
    localparam int DEF_WPADDEPTH = 16;
    localparam int CONF_TW       = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_PSIN,
        S_COMPUTE,
        S_DRAIN,
        S_OUT
    } PEMacState;

    typedef struct packed {
        logic [CONF_TW-1:0] taps;
        logic               reuse_w;
        logic               psum_in;
    } PEMacConf;
endpackage

// File: rtl/pe_mac_array_lane.sv
// pe_mac_lane: one MAC lane holding its weight pad, FS/MS/SS pipeline and accumulator.
// Build option PE_MAC_SAT_EN: the SS add saturates instead of wrapping.
module pe_mac_lane
    import PEMacCfg::*;
#(
    parameter int DWD       = DEF_DWD,
    parameter int PSUMDWD   = DEF_PSUMDWD,
    parameter int WPADDEPTH = DEF_WPADDEPTH,
    parameter int AW        = $clog2(WPADDEPTH)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wr_en,
    input  logic [AW-1:0]      i_wr_addr,
    input  logic [DWD-1:0]     i_wr_data,
    input  logic               i_clr,
    input  logic               i_seed,
    input  logic [PSUMDWD-1:0] i_psum_in,
    input  logic               i_fs_en,
    input  logic [AW-1:0]      i_tap,
    input  logic [DWD-1:0]     i_x,
    input  logic               i_ss_en,
    output logic [PSUMDWD-1:0] o_acc
);
    logic [WPADDEPTH-1:0][DWD-1:0] r_pad;
    logic signed [DWD-1:0]         r_x;
    logic signed [DWD-1:0]         r_w;
    logic signed [2*DWD-1:0]       r_prod;
    logic signed [PSUMDWD-1:0]     r_acc;
    logic signed [PSUMDWD-1:0]     w_ext;
    logic signed [PSUMDWD-1:0]     w_sum;

    assign w_ext = PSUMDWD'(r_prod);

`ifdef PE_MAC_SAT_EN
    logic signed [PSUMDWD:0] w_wide;
    // One guard bit is enough: a single product never exceeds the psum range.
    assign w_wide = (PSUMDWD+1)'(r_acc) + (PSUMDWD+1)'(w_ext);
    assign w_sum  = (w_wide[PSUMDWD] != w_wide[PSUMDWD-1])
                  ? {w_wide[PSUMDWD], {(PSUMDWD-1){~w_wide[PSUMDWD]}}}
                  : w_wide[PSUMDWD-1:0];
`else
    assign w_sum = r_acc + w_ext;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_pad <= '0;
        end else if (i_wr_en) begin
            r_pad[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_x    <= '0;
            r_w    <= '0;
            r_prod <= '0;
            r_acc  <= '0;
        end else begin
            if (i_fs_en) begin
                r_x <= i_x;
                r_w <= r_pad[i_tap];
            end
            r_prod <= r_x * r_w;
            if (i_clr)
                r_acc <= '0;
            else if (i_seed)
                r_acc <= i_psum_in;
            else if (i_ss_en)
                r_acc <= w_sum;
        end
    end

    assign o_acc = r_acc;
endmodule

// File: rtl/pe_mac_array.sv
// pe_mac_array: ROWS MAC lanes sharing a broadcast input stream, sequenced by a handshake FSM.
// Build option PE_MAC_SAT_EN: lanes saturate their accumulators instead of wrapping.
module pe_mac_array
    import PEMacCfg::*;
#(
    parameter int ROWS      = DEF_ROWS,
    parameter int DWD       = DEF_DWD,
    parameter int PSUMDWD   = DEF_PSUMDWD,
    parameter int WPADDEPTH = DEF_WPADDEPTH,
    parameter int KW        = $clog2(WPADDEPTH+1)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         Cfg_rdy,
    output logic                         Cfg_ack,
    input  logic [KW-1:0]                i_cfg_taps,
    input  logic                         i_cfg_reuse_w,
    input  logic                         i_cfg_psum_in,
    input  logic                         Weight_rdy,
    output logic                         Weight_ack,
    input  logic [ROWS-1:0][DWD-1:0]     i_weight,
    input  logic                         Input_rdy,
    output logic                         Input_ack,
    input  logic [DWD-1:0]               i_input,
    input  logic                         Psum_in_rdy,
    output logic                         Psum_in_ack,
    input  logic [ROWS-1:0][PSUMDWD-1:0] i_psum_in,
    output logic                         Psum_out_rdy,
    input  logic                         Psum_out_ack,
    output logic [ROWS-1:0][PSUMDWD-1:0] o_psum,
    output logic                         o_busy
);
    localparam int AW = $clog2(WPADDEPTH);

    PEMacState                    r_state;
    PEMacState                    w_next;
    PEMacConf                     r_cfg;
    logic [KW-1:0]                r_cnt;
    logic [KW-1:0]                w_taps;
    logic [KW-1:0]                w_k;
    logic [2:0]                   r_vld;
    logic                         w_last;
    logic                         w_cfg_xfer;
    logic                         w_wt_xfer;
    logic                         w_ps_xfer;
    logic                         w_in_xfer;
    logic                         w_unused;
    logic [ROWS-1:0][PSUMDWD-1:0] w_acc;

    assign w_taps     = (i_cfg_taps > KW'(WPADDEPTH)) ? KW'(WPADDEPTH) : i_cfg_taps;
    assign w_k        = r_cfg.taps[KW-1:0];
    assign w_last     = (r_cnt + KW'(1)) == w_k;
    assign w_cfg_xfer = Cfg_rdy && Cfg_ack;
    assign w_wt_xfer  = Weight_rdy && Weight_ack;
    assign w_ps_xfer  = Psum_in_rdy && Psum_in_ack;
    assign w_in_xfer  = Input_rdy && Input_ack;
    assign w_unused   = ^{r_cfg.taps[CONF_TW-1:KW], r_cfg.reuse_w};
    assign o_busy     = r_state != S_IDLE;
    assign o_psum     = (r_state == S_OUT) ? w_acc : '0;

    always_comb begin
        w_next       = r_state;
        Cfg_ack      = 1'b0;
        Weight_ack   = 1'b0;
        Psum_in_ack  = 1'b0;
        Input_ack    = 1'b0;
        Psum_out_rdy = 1'b0;
        case (r_state)
            S_IDLE: begin
                Cfg_ack = i_rst;
                if (Cfg_rdy)
                    w_next = (!i_cfg_reuse_w && w_taps != '0) ? S_LOAD_W
                           : i_cfg_psum_in ? S_PSIN : S_COMPUTE;
            end
            S_LOAD_W: begin
                Weight_ack = 1'b1;
                if (Weight_rdy && w_last)
                    w_next = r_cfg.psum_in ? S_PSIN : S_COMPUTE;
            end
            S_PSIN: begin
                Psum_in_ack = 1'b1;
                if (Psum_in_rdy)
                    w_next = S_COMPUTE;
            end
            S_COMPUTE: begin
                Input_ack = r_cnt < w_k;
                if (w_k == '0)
                    w_next = S_OUT;
                else if (Input_rdy && w_last)
                    w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_vld == '0)
                    w_next = S_OUT;
            end
            S_OUT: begin
                Psum_out_rdy = 1'b1;
                if (Psum_out_ack)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // r_vld[0]/[1]/[2]: FS, MS and SS stages hold a real tap; DRAIN waits for all three to empty.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_cfg   <= '0;
            r_cnt   <= '0;
            r_vld   <= '0;
        end else begin
            r_state <= w_next;
            if (w_cfg_xfer)
                r_cfg <= '{taps: CONF_TW'(w_taps), reuse_w: i_cfg_reuse_w, psum_in: i_cfg_psum_in};
            r_cnt <= (w_next != r_state) ? '0
                   : (w_wt_xfer || w_in_xfer) ? r_cnt + KW'(1) : r_cnt;
            r_vld <= {r_vld[1:0], w_in_xfer};
        end
    end

    for (genvar g = 0; g < ROWS; g++) begin : g_lane
        pe_mac_lane #(
            .DWD       (DWD),
            .PSUMDWD   (PSUMDWD),
            .WPADDEPTH (WPADDEPTH)
        ) u_lane (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_wr_en   (w_wt_xfer),
            .i_wr_addr (r_cnt[AW-1:0]),
            .i_wr_data (i_weight[g]),
            .i_clr     (w_cfg_xfer),
            .i_seed    (w_ps_xfer),
            .i_psum_in (i_psum_in[g]),
            .i_fs_en   (w_in_xfer),
            .i_tap     (r_cnt[AW-1:0]),
            .i_x       (i_input),
            .i_ss_en   (r_vld[1]),
            .o_acc     (w_acc[g])
        );
    end
endmodule
